// File: rtl/conv_sequencer.sv
// Convolution tap/output sequencer: K*K taps + MAC_LAT wait + 1 out cycle per output, all outputs registered.
// Backpressure: holds out_valid and coordinates in OUT until out_ready; no taps issue while stalled.
module conv_sequencer #(
  parameter int H       = 256,
  parameter int W       = 256,
  parameter int PADDING = 1,
  parameter int FILTERS = 64,
  parameter int K       = 3,
  parameter int MAC_LAT = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  output logic                             tap_valid,
  output logic                             tap_first,
  output logic                             tap_last,
  output logic                             tap_pad,
  output logic [$clog2(H)-1:0]             in_row,
  output logic [$clog2(W)-1:0]             in_col,
  output logic [$clog2(FILTERS*K*K)-1:0]   w_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(H)-1:0]             out_row,
  output logic [$clog2(W)-1:0]             out_col,
  output logic [$clog2(FILTERS)-1:0]       out_filt
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int FW = $clog2(FILTERS);
  localparam int AW = $clog2(FILTERS*K*K);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RUN, WAIT, OUT, DONE} state_t;

  state_t          state_q, state_n;
  logic [RW-1:0]   row_q, row_n;
  logic [CW-1:0]   col_q, col_n;
  logic [FW-1:0]   filt_q, filt_n;
  logic [KW-1:0]   ky_q, ky_n, kx_q, kx_n;
  logic [LW-1:0]   wcnt_q, wcnt_n;

  int              ir_n, ic_n, wa_n;
  logic            pad_n;

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    filt_n  = filt_q;
    ky_n    = ky_q;
    kx_n    = kx_q;
    wcnt_n  = wcnt_q;
    // abort wins over start and over a same-cycle transfer; counters are left as-is
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          row_n   = '0;
          col_n   = '0;
          filt_n  = '0;
          ky_n    = '0;
          kx_n    = '0;
          state_n = RUN;
        end
        RUN: begin
          if (kx_q == KW'(K-1)) begin
            kx_n = '0;
            if (ky_q == KW'(K-1)) begin
              ky_n    = '0;
              wcnt_n  = '0;
              state_n = (MAC_LAT == 0) ? OUT : WAIT;
            end else begin
              ky_n = ky_q + KW'(1);
            end
          end else begin
            kx_n = kx_q + KW'(1);
          end
        end
        WAIT: begin
          if (wcnt_q == LW'(MAC_LAT-1)) state_n = OUT;
          else                          wcnt_n  = wcnt_q + LW'(1);
        end
        OUT: if (out_ready) begin
          if (row_q == RW'(H-1) && col_q == CW'(W-1) && filt_q == FW'(FILTERS-1))
            state_n = DONE;
          else
            state_n = RUN;
          if (filt_q == FW'(FILTERS-1)) begin
            filt_n = '0;
            if (col_q == CW'(W-1)) begin
              col_n = '0;
              row_n = (row_q == RW'(H-1)) ? '0 : row_q + RW'(1);
            end else begin
              col_n = col_q + CW'(1);
            end
          end else begin
            filt_n = filt_q + FW'(1);
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

    // Tap fields are precomputed from next-state counters so they can be registered.
    ir_n  = int'(row_n) + int'(ky_n) - PADDING;
    ic_n  = int'(col_n) + int'(kx_n) - PADDING;
    wa_n  = (int'(filt_n) * K + int'(ky_n)) * K + int'(kx_n);
    pad_n = (ir_n < 0) || (ir_n >= H) || (ic_n < 0) || (ic_n >= W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      filt_q    <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      wcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      tap_valid <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      tap_pad   <= 1'b0;
      in_row    <= '0;
      in_col    <= '0;
      w_addr    <= '0;
    end else begin
      state_q   <= state_n;
      row_q     <= row_n;
      col_q     <= col_n;
      filt_q    <= filt_n;
      ky_q      <= ky_n;
      kx_q      <= kx_n;
      wcnt_q    <= wcnt_n;
      busy      <= (state_n == RUN) || (state_n == WAIT) || (state_n == OUT);
      done      <= (state_n == DONE);
      out_valid <= (state_n == OUT);
      if (state_n == RUN) begin
        tap_valid <= 1'b1;
        tap_first <= (ky_n == '0) && (kx_n == '0);
        tap_last  <= (ky_n == KW'(K-1)) && (kx_n == KW'(K-1));
        tap_pad   <= pad_n;
        in_row    <= pad_n ? '0 : RW'(ir_n);
        in_col    <= pad_n ? '0 : CW'(ic_n);
        w_addr    <= AW'(wa_n);
      end else begin
        tap_valid <= 1'b0;
        tap_first <= 1'b0;
        tap_last  <= 1'b0;
        tap_pad   <= 1'b0;
        in_row    <= '0;
        in_col    <= '0;
        w_addr    <= '0;
      end
    end
  end

  assign out_row  = row_q;
  assign out_col  = col_q;
  assign out_filt = filt_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer at H=W=4, PADDING=1, FILTERS=2, K=3, MAC_LAT=2.
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ready;
  logic       busy, done, tap_valid, tap_first, tap_last, tap_pad, out_valid;
  logic [1:0] in_row, in_col, out_row, out_col;
  logic [4:0] w_addr;
  logic [0:0] out_filt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run_cyc, padcnt;
  logic seen_done;

  conv_sequencer #(.H(4), .W(4), .PADDING(1), .FILTERS(2), .K(3), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .tap_valid(tap_valid), .tap_first(tap_first), .tap_last(tap_last), .tap_pad(tap_pad),
    .in_row(in_row), .in_col(in_col), .w_addr(w_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_filt(out_filt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tapvec();
    return 32'({tap_valid, tap_first, tap_last, tap_pad, in_row, in_col, w_addr});
  endfunction

  // Expected tap fields: ir = r+ky-1, ic = c+kx-1, padded outside 0..3.
  function automatic logic [31:0] exp_tap(int r, int c, int f, int ky, int kx);
    int   ir, ic;
    logic pad;
    ir  = r + ky - 1;
    ic  = c + kx - 1;
    pad = (ir < 0) || (ir > 3) || (ic < 0) || (ic > 3);
    return 32'({1'b1, (ky == 0 && kx == 0), (ky == 2 && kx == 2), pad,
                pad ? 2'd0 : 2'(ir), pad ? 2'd0 : 2'(ic), 5'((f * 3 + ky) * 3 + kx)});
  endfunction

  function automatic logic [31:0] outvec();
    return 32'({busy, out_valid, tap_valid, out_row, out_col, out_filt});
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    check("reset_state", 32'({busy, done, tap_valid, out_valid, tap_pad, w_addr, out_row, out_col, out_filt}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_after_reset", 32'({busy, done, tap_valid}), 32'd0);

    // Full pass with out_ready held high.
    start = 1'b1; tick(); start = 1'b0;
    run_cyc = cyc;
    for (int o = 0; o < 32; o++) begin
      int r, c, f;
      r = o / 8; c = (o / 2) % 4; f = o % 2;
      padcnt = 0;
      for (int t = 0; t < 9; t++) begin
        check("tap", tapvec(), exp_tap(r, c, f, t / 3, t % 3));
        check("run_coords", outvec(), 32'({1'b1, 1'b0, 1'b1, 2'(r), 2'(c), 1'(f)}));
        if (tap_pad) padcnt++;
        if (o == 0 && t == 4) check("tap11_of_000", 32'({tap_pad, in_row, in_col, w_addr}), 32'({1'b0, 2'd0, 2'd0, 5'd4}));
        if (o == 23 && t == 8) check("tap22_of_231", 32'({tap_pad, w_addr}), 32'({1'b1, 5'd17}));
        if (o == 3 && t == 2) start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (o == 0) check("pad_count_000", 32'(padcnt), 32'd5);
      repeat (2) begin
        check("wait", 32'({busy, tap_valid, out_valid}), 32'b100);
        tick();
      end
      check("out", outvec(), 32'({1'b1, 1'b1, 1'b0, 2'(r), 2'(c), 1'(f)}));
      tick();
    end
    check("done_pulse", 32'({done, busy, tap_valid, out_valid}), 32'b1000);
    check("done_latency", 32'(cyc - run_cyc), 32'd384);
    tick();
    check("after_done", 32'({done, busy}), 32'd0);

    // Second pass: stall at output 2, abort on the 4th tap of output 5.
    start = 1'b1; tick(); start = 1'b0;
    for (int o = 0; o < 5; o++) begin
      repeat (11) tick();
      if (o == 2) begin
        check("stall_enter", outvec(), 32'({1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'd0}));
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_hold", outvec(), 32'({1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'd0}));
        end
        out_ready = 1'b1;
      end
      tick();
      if (o == 2) check("stall_release", outvec(), 32'({1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'd1}));
    end
    repeat (3) tick();
    check("abort_tap", tapvec(), exp_tap(0, 2, 1, 1, 0));
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", 32'({busy, done, tap_valid, out_valid}), 32'd0);
    seen_done = 1'b0;
    repeat (20) begin
      tick();
      seen_done = seen_done | done | busy;
    end
    check("abort_quiet", 32'(seen_done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_tap", tapvec(), exp_tap(0, 0, 0, 0, 0));
    check("restart_coords", outvec(), 32'({1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'd0}));

    // Async reset during WAIT of output (0,0,1).
    repeat (21) tick();
    check("pre_reset_wait", outvec(), 32'({1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'd1}));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'({busy, done, tap_valid, tap_first, tap_last, tap_pad, out_valid,
                              in_row, in_col, w_addr, out_row, out_col, out_filt}), 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", 32'({busy, tap_valid, out_valid, done}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameters (name, default, meaning): H, 256, output/input image rows.
REQ-002 W, 256, output/input image columns.
REQ-003 PADDING, 1, zero-pad border width.
REQ-004 FILTERS, 64, output filter count.
REQ-005 K, 3, square kernel size.
REQ-006 MAC_LAT, 2, fixed cycles from the last tap strobe to a valid accumulator result in the external MAC datapath.
REQ-007 Clocking is decided: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-008 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- start, in, 1, begin one full layer pass.
- abort, in, 1, cancel pass.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pass-complete pulse.
REQ-009 Tap ports:
- tap_valid, out, 1, MAC tap strobe.
- tap_first, out, 1, clear accumulator on this tap.
- tap_last, out, 1, final tap of output.
- tap_pad, out, 1, tap lies in padding, so the MAC uses operand 0.
- in_row, out, clog2(H), input pixel row.
- in_col, out, clog2(W), input pixel column.
- w_addr, out, clog2(FILTERS*K*K), weight address.
REQ-010 Output ports:
- out_valid, out, 1, result ready to store.
- out_ready, in, 1, sink accepts.
- out_row, out, clog2(H), output row.
- out_col, out, clog2(W), output column.
- out_filt, out, clog2(FILTERS), filter index; also the bias address.

Function
REQ-011 FSM states SHALL be IDLE, RUN, WAIT, OUT, DONE.
REQ-012 IDLE: start=1 SHALL clear counters (row, col, filt, ky, kx) to 0 and enter RUN next cycle; busy SHALL be 1 in RUN, WAIT and OUT.
REQ-013 start SHALL be ignored in every state except IDLE.
REQ-014 RUN SHALL assert tap_valid for exactly K*K consecutive cycles, stepping kx fastest and then ky from (0,0) to (K-1,K-1).
REQ-015 tap_first SHALL be 1 only on tap (0,0), and tap_last SHALL be 1 only on tap (K-1,K-1).
REQ-016 Input coordinates SHALL be computed with signed arithmetic: ir = out_row + ky - PADDING and ic = out_col + kx - PADDING.
REQ-017 tap_pad SHALL be 1 when ir<0, ir>=H, ic<0 or ic>=W. While tap_pad=1, in_row and in_col SHALL be driven to 0; otherwise they carry ir and ic.
REQ-018 w_addr SHALL be (filt*K + ky)*K + kx.
REQ-019 After tap_last, the FSM SHALL enter WAIT for exactly MAC_LAT cycles with tap_valid=0, then enter OUT.
REQ-020 OUT SHALL hold out_valid=1 with out_row, out_col and out_filt stable until out_ready=1. The transfer completes on the cycle out_valid&&out_ready.
REQ-021 On transfer, the sequencer SHALL advance with filt fastest, then col, then row. Each counter wraps to 0 and carries into the next.
REQ-022 On transfer, if the transferred output was not the last, the FSM SHALL return to RUN next cycle.
REQ-023 If the transferred output was (H-1, W-1, FILTERS-1), the FSM SHALL enter DONE.
REQ-024 DONE SHALL assert done=1 for one cycle with busy=0, then enter IDLE.
REQ-025 With out_ready held at 1, each output SHALL take K*K+MAC_LAT+1 cycles.
REQ-026 abort=1 in any state SHALL force IDLE next cycle. In that cycle tap_valid, out_valid and done SHALL all be 0. abort SHALL take priority over start and over a simultaneous transfer.
REQ-027 All outputs SHALL be registered; no combinational path SHALL run from out_ready to tap_valid.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, all counters to 0, and all outputs to 0, including busy, done, tap_* and out_valid. This holds mid-pass.
REQ-029 After rst_n deasserts, the block SHALL take no action until a new start.

Verification (H=W=4, PADDING=1, FILTERS=2, K=3, MAC_LAT=2)
REQ-030 start pulse with out_ready=1 -> 32 out_valid transfers in order (0,0,0), (0,0,1), (0,1,0) ... (3,3,1); done pulses exactly 12*32 cycles after RUN entry.
REQ-031 First output (0,0,0) -> taps with ky=0 or kx=0 have tap_pad=1 (5 of 9 taps); the tap (1,1) gives in_row=0, in_col=0 and w_addr=4.
REQ-032 Filter 1 at output (2,3), tap (2,2) -> tap_pad=1 because ic=4 equals W; w_addr=17.
REQ-033 out_ready held 0 for 5 cycles during OUT -> out_valid and coordinates remain stable, no tap_valid is issued, and advance occurs the cycle after out_ready rises.
REQ-034 abort on the 4th tap of output 5 -> next cycle IDLE, busy=0, no done pulse; a new start restarts at (0,0,0).
REQ-035 rst_n low during WAIT -> all outputs 0 immediately; start asserted during busy is ignored, with no counter change.
